// File: rtl/branch_nzp_unit_if.sv
// Signal bundle between the thread-lane scheduler/decoder and branch_nzp_unit.
// Defining BRANCH_NZP_TAKEN_COUNT_EN adds the taken_count observation signal.
interface branch_nzp_unit_if #(
  parameter int PC_BITS   = 8,
  parameter int DATA_BITS = 8
);
  logic                 enable;
  logic [2:0]           core_state;
  logic [2:0]           decoded_nzp;
  logic [PC_BITS-1:0]   decoded_immediate;
  logic                 decoded_nzp_write_enable;
  logic                 decoded_pc_mux;
  logic                 decoded_call;
  logic                 decoded_ret;
  logic [DATA_BITS-1:0] alu_out;
  logic [PC_BITS-1:0]   current_pc;
  logic [PC_BITS-1:0]   next_pc;
  logic [2:0]           nzp;
  logic                 stack_err;
`ifdef BRANCH_NZP_TAKEN_COUNT_EN
  logic [15:0]          taken_count;
`endif

  // Strobe-style bus: no valid/ready; inputs are qualified by enable and core_state
  // each cycle, and outputs are registered state that is always valid.
  modport master (
    output enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_call, decoded_ret,
           alu_out, current_pc,
`ifdef BRANCH_NZP_TAKEN_COUNT_EN
    input  taken_count,
`endif
    input  next_pc, nzp, stack_err
  );

  modport slave (
    input  enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_call, decoded_ret,
           alu_out, current_pc,
`ifdef BRANCH_NZP_TAKEN_COUNT_EN
    output taken_count,
`endif
    output next_pc, nzp, stack_err
  );
endinterface

// File: rtl/branch_nzp_unit.sv
// Per-thread NZP flag register and next-PC resolver with a return-address stack.
// Optional taken-transfer counter enabled by defining BRANCH_NZP_TAKEN_COUNT_EN.
module branch_nzp_unit #(
  parameter int PC_BITS     = 8,
  parameter int DATA_BITS   = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  branch_nzp_unit_if.slave   bus
);
  localparam logic [2:0] ST_EXECUTE = 3'b101;
  localparam logic [2:0] ST_UPDATE  = 3'b110;
  localparam int SP_BITS  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_BITS = $clog2(STACK_DEPTH);
  localparam logic [SP_BITS-1:0] SP_FULL = SP_BITS'(STACK_DEPTH);

  logic [PC_BITS-1:0]  next_pc_q, next_pc_d;
  logic [2:0]          nzp_q, nzp_d;
  logic [SP_BITS-1:0]  sp_q, sp_d;
  logic                err_q, err_d;
  logic [PC_BITS-1:0]  stack_q [STACK_DEPTH];

  logic [PC_BITS-1:0]  pc_inc;
  logic [IDX_BITS-1:0] top_idx;
  logic [IDX_BITS-1:0] push_idx;
  logic                push_en;
  logic                transfer;

  // Only the compare flags are consumed; the upper ALU bits are intentionally ignored.
  logic                unused_alu_bits;
  assign unused_alu_bits = ^bus.alu_out[DATA_BITS-1:3];

  assign pc_inc   = bus.current_pc + PC_BITS'(1);
  assign top_idx  = IDX_BITS'(sp_q - SP_BITS'(1));
  assign push_idx = IDX_BITS'(sp_q);

  always_comb begin
    next_pc_d = next_pc_q;
    nzp_d     = nzp_q;
    sp_d      = sp_q;
    err_d     = err_q;
    push_en   = 1'b0;
    transfer  = 1'b0;
    if (bus.enable) begin
      if (bus.core_state == ST_EXECUTE) begin
        if (bus.decoded_ret) begin
          if (sp_q != '0) begin
            next_pc_d = stack_q[top_idx];
            sp_d      = sp_q - SP_BITS'(1);
            transfer  = 1'b1;
          end else begin
            next_pc_d = pc_inc;
            err_d     = 1'b1;
          end
        end else if (bus.decoded_call) begin
          if (sp_q != SP_FULL) begin
            next_pc_d = bus.decoded_immediate;
            sp_d      = sp_q + SP_BITS'(1);
            push_en   = 1'b1;
            transfer  = 1'b1;
          end else begin
            next_pc_d = pc_inc;
            err_d     = 1'b1;
          end
        end else if (bus.decoded_pc_mux && ((nzp_q & bus.decoded_nzp) != 3'b000)) begin
          next_pc_d = bus.decoded_immediate;
          transfer  = 1'b1;
        end else begin
          next_pc_d = pc_inc;
        end
      end else if (bus.core_state == ST_UPDATE) begin
        if (bus.decoded_nzp_write_enable) begin
          nzp_d = bus.alu_out[2:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc_q <= '0;
      nzp_q     <= '0;
      sp_q      <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      next_pc_q <= next_pc_d;
      nzp_q     <= nzp_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      if (push_en) begin
        stack_q[push_idx] <= pc_inc;
      end
    end
  end

  assign bus.next_pc   = next_pc_q;
  assign bus.nzp       = nzp_q;
  assign bus.stack_err = err_q;

`ifdef BRANCH_NZP_TAKEN_COUNT_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;

  // A CALL or branch whose target happens to equal pc+1 is not a redirect.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (transfer && (next_pc_d != pc_inc) && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.taken_count = taken_cnt_q;
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
`endif
endmodule

// File: tb/tb_branch_nzp_unit.sv
// Bench for branch_nzp_unit: directed cycle table, hand sequences and a random run
// against a queue-based reference model.
module tb_branch_nzp_unit;
  localparam logic [2:0] EX = 3'b101;
  localparam logic [2:0] UP = 3'b110;
  localparam logic [2:0] ID = 3'b000;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] st;
    logic [2:0] dnzp;
    logic [7:0] imm;
    logic       we;
    logic       pcmux;
    logic       call;
    logic       ret;
    logic [7:0] alu;
    logic [7:0] pc;
    logic [7:0] exp_pc;
    logic [2:0] exp_nzp;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_nzp_unit_if #(.PC_BITS(8), .DATA_BITS(8)) bus ();

  branch_nzp_unit #(.PC_BITS(8), .DATA_BITS(8), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state: return addresses as a plain LIFO queue.
  logic [7:0]  m_pc;
  logic [2:0]  m_nzp;
  logic        m_err;
  logic [15:0] m_cnt;
  logic [7:0]  ras_q[$];

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic en, logic [2:0] st, logic [2:0] dnzp,
                              logic [7:0] imm, logic we, logic pcmux, logic call,
                              logic ret, logic [7:0] alu, logic [7:0] pc,
                              logic [7:0] exp_pc, logic [2:0] exp_nzp, logic exp_err);
    vec_t v;
    v.rst = rst; v.en = en; v.st = st; v.dnzp = dnzp; v.imm = imm; v.we = we;
    v.pcmux = pcmux; v.call = call; v.ret = ret; v.alu = alu; v.pc = pc;
    v.exp_pc = exp_pc; v.exp_nzp = exp_nzp; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input vec_t v);
    logic [7:0] inc;
    logic       moved;
    inc   = v.pc + 8'd1;
    moved = 1'b0;
    if (v.rst) begin
      m_pc = 8'h00; m_nzp = 3'b000; m_err = 1'b0; m_cnt = 16'h0000;
      ras_q.delete();
    end else if (v.en && v.st == EX) begin
      if (v.ret) begin
        if (ras_q.size() > 0) begin
          m_pc = ras_q.pop_back();
          moved = 1'b1;
        end else begin
          m_pc = inc; m_err = 1'b1;
        end
      end else if (v.call) begin
        if (ras_q.size() < 4) begin
          ras_q.push_back(inc);
          m_pc = v.imm;
          moved = 1'b1;
        end else begin
          m_pc = inc; m_err = 1'b1;
        end
      end else if (v.pcmux && (m_nzp & v.dnzp) != 3'b000) begin
        m_pc = v.imm;
        moved = 1'b1;
      end else begin
        m_pc = inc;
      end
      if (moved && m_pc != inc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (v.en && v.st == UP && v.we) begin
      m_nzp = v.alu[2:0];
    end
  endtask

  // Drive one cycle, advance the model at the edge, leave time 1 unit after the edge.
  task automatic apply(input vec_t v);
    reset                        = v.rst;
    bus.enable                   = v.en;
    bus.core_state               = v.st;
    bus.decoded_nzp              = v.dnzp;
    bus.decoded_immediate        = v.imm;
    bus.decoded_nzp_write_enable = v.we;
    bus.decoded_pc_mux           = v.pcmux;
    bus.decoded_call             = v.call;
    bus.decoded_ret              = v.ret;
    bus.alu_out                  = v.alu;
    bus.current_pc               = v.pc;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic check_vs_model(input string tag);
    check({tag, ".next_pc"},   16'(bus.next_pc),   16'(m_pc));
    check({tag, ".nzp"},       16'(bus.nzp),       16'(m_nzp));
    check({tag, ".stack_err"}, 16'(bus.stack_err), 16'(m_err));
`ifdef BRANCH_NZP_TAKEN_COUNT_EN
    check({tag, ".taken_count"}, bus.taken_count, m_cnt);
`endif
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".next_pc"},   16'(bus.next_pc),   16'(v.exp_pc));
    check({tag, ".nzp"},       16'(bus.nzp),       16'(v.exp_nzp));
    check({tag, ".stack_err"}, 16'(bus.stack_err), 16'(v.exp_err));
`ifdef BRANCH_NZP_TAKEN_COUNT_EN
    check({tag, ".taken_count"}, bus.taken_count, m_cnt);
`endif
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    m_pc = '0; m_nzp = '0; m_err = 1'b0; m_cnt = '0;
    //      rst  en  st  dnzp   imm   we   mux  call ret  alu    pc     epc    enzp   eerr
    tbl.push_back(mk(1, 1, ID, 3'b000, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0));
    tbl.push_back(mk(0, 1, UP, 3'b000, 8'h00, 1, 0, 0, 0, 8'h04, 8'h00, 8'h00, 3'b100, 0));
    tbl.push_back(mk(0, 1, UP, 3'b000, 8'h00, 1, 0, 0, 0, 8'h02, 8'h00, 8'h00, 3'b010, 0));
    tbl.push_back(mk(0, 1, EX, 3'b010, 8'h20, 0, 1, 0, 0, 8'h00, 8'h05, 8'h20, 3'b010, 0));
    tbl.push_back(mk(0, 1, EX, 3'b101, 8'h20, 0, 1, 0, 0, 8'h00, 8'h05, 8'h06, 3'b010, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h40, 0, 0, 1, 0, 8'h00, 8'h10, 8'h40, 3'b010, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h45, 8'h11, 3'b010, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h80, 0, 0, 1, 0, 8'h00, 8'h01, 8'h80, 3'b010, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h80, 0, 0, 1, 0, 8'h00, 8'h02, 8'h80, 3'b010, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h80, 0, 0, 1, 0, 8'h00, 8'h03, 8'h80, 3'b010, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h80, 0, 0, 1, 0, 8'h00, 8'h04, 8'h80, 3'b010, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h50, 0, 0, 1, 0, 8'h00, 8'h30, 8'h31, 3'b010, 1));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h90, 8'h05, 3'b010, 1));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h90, 8'h04, 3'b010, 1));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h90, 8'h03, 3'b010, 1));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h90, 8'h02, 3'b010, 1));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h60, 8'h61, 3'b010, 1));
    tbl.push_back(mk(1, 1, ID, 3'b000, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 3'b000, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h33, 0, 0, 1, 0, 8'h00, 8'hFF, 8'h33, 3'b000, 0));
    tbl.push_back(mk(0, 0, EX, 3'b000, 8'h77, 0, 0, 1, 0, 8'h00, 8'h10, 8'h33, 3'b000, 0));
    tbl.push_back(mk(0, 0, UP, 3'b000, 8'h00, 1, 0, 0, 0, 8'h07, 8'h10, 8'h33, 3'b000, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h50, 8'h00, 3'b000, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h44, 0, 0, 1, 0, 8'h00, 8'h20, 8'h44, 3'b000, 0));
    tbl.push_back(mk(0, 1, EX, 3'b111, 8'h99, 0, 1, 1, 1, 8'h00, 8'h30, 8'h21, 3'b000, 0));
    tbl.push_back(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h70, 8'h71, 3'b000, 1));
    tbl.push_back(mk(0, 1, ID, 3'b000, 8'h55, 0, 0, 1, 0, 8'h00, 8'h08, 8'h71, 3'b000, 1));
    tbl.push_back(mk(0, 1, UP, 3'b111, 8'h55, 0, 1, 1, 1, 8'h07, 8'h08, 8'h71, 3'b000, 1));
    tbl.push_back(mk(0, 1, UP, 3'b000, 8'h00, 1, 0, 0, 0, 8'hF1, 8'h08, 8'h71, 3'b001, 1));
    tbl.push_back(mk(0, 1, EX, 3'b001, 8'hAB, 0, 1, 0, 0, 8'h00, 8'h09, 8'hAB, 3'b001, 1));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      check_vec($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // Reset while two return addresses are stacked: the next RET must underflow.
    apply(mk(1, 1, ID, 3'b000, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0));
    apply(mk(0, 1, EX, 3'b000, 8'h10, 0, 0, 1, 0, 8'h00, 8'h01, 8'h00, 3'b000, 0));
    apply(mk(0, 1, EX, 3'b000, 8'h20, 0, 0, 1, 0, 8'h00, 8'h02, 8'h00, 3'b000, 0));
    check("seq_rst.call2", 16'(bus.next_pc), 16'h0020);
    apply(mk(1, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h40, 8'h00, 3'b000, 0));
    check("seq_rst.abort_pc", 16'(bus.next_pc), 16'h0000);
    check("seq_rst.abort_err", 16'(bus.stack_err), 16'h0000);
    apply(mk(0, 1, EX, 3'b000, 8'h00, 0, 0, 0, 1, 8'h00, 8'h05, 8'h00, 3'b000, 0));
    check("seq_rst.ret_pc", 16'(bus.next_pc), 16'h0006);
    check("seq_rst.ret_err", 16'(bus.stack_err), 16'h0001);
    check_vs_model("seq_rst");

    // Random run against the reference model.
    apply(mk(1, 1, ID, 3'b000, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0));
    for (int n = 0; n < 600; n++) begin
      int sel;
      v.rst   = ($urandom_range(0, 59) == 0);
      v.en    = ($urandom_range(0, 7) != 0);
      sel     = $urandom_range(0, 9);
      v.st    = (sel < 5) ? EX : (sel < 8) ? UP : 3'($urandom_range(0, 4));
      v.dnzp  = 3'($urandom_range(0, 7));
      v.imm   = 8'($urandom_range(0, 255));
      v.we    = ($urandom_range(0, 1) == 1);
      v.pcmux = ($urandom_range(0, 1) == 1);
      v.call  = ($urandom_range(0, 2) == 0);
      v.ret   = ($urandom_range(0, 2) == 0);
      v.alu   = 8'($urandom_range(0, 255));
      v.pc    = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      v.exp_pc = '0; v.exp_nzp = '0; v.exp_err = 1'b0;
      apply(v);
      check_vs_model($sformatf("rnd[%0d]", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
